// File: rtl/instr_fetch_seq.sv
// Instruction fetch/sequencing stage for the 4-bit-opcode accumulator CPU.
// Owns PC and IR, fetches over a req/ack handshake, and strobes exec_en
// once per instruction so downstream side effects happen exactly once.
module instr_fetch_seq #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [3:0]         opcode,
    output logic [INSTR_W-5:0] operand,
    input  logic               pc_src,
    input  logic               jmp_uncond,
    input  logic               dmem_busy,
    output logic               exec_en,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_d;
    logic [INSTR_W-1:0] ir_q;
    logic               halted_q;
    logic               req_q;
    logic               fire;

    // An instruction retires in the EXEC cycle where data side is ready.
    assign fire = (state_q == S_EXEC) && !dmem_busy;

    // Next PC: jump target (low operand bits), hold on illegal opcode, else +1 with wrap.
    always_comb begin
        pc_d = pc_q;
        if (fire) begin
            if (jmp_uncond)
                pc_d = ir_q[ADDR_W-1:0];
            else if (!pc_src)
                pc_d = pc_q + ADDR_W'(1);
        end
    end

    // Sequencer FSM: FETCH -> DECODE -> EXEC -> FETCH, or into HALT on an illegal opcode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            halted_q <= 1'b0;
            req_q    <= 1'b0;
        end else begin
            pc_q <= pc_d;
            case (state_q)
                S_FETCH: begin
                    // ack is honoured even in the partial cycle right after reset release
                    if (imem_ack) begin
                        ir_q    <= imem_rdata;
                        req_q   <= 1'b0;
                        state_q <= S_DECODE;
                    end else begin
                        req_q   <= 1'b1;
                    end
                end
                S_DECODE: begin
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (!dmem_busy) begin
                        if (!jmp_uncond && pc_src) begin
                            halted_q <= 1'b1;
                            req_q    <= 1'b0;
                            state_q  <= S_HALT;
                        end else begin
                            req_q    <= 1'b1;
                            state_q  <= S_FETCH;
                        end
                    end
                end
                default: begin
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    // exec_en follows dmem_busy in the same cycle; async reset forces state out of EXEC.
    assign exec_en   = fire;
    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign halted    = halted_q;
    assign opcode    = ir_q[INSTR_W-1:INSTR_W-4];
    assign operand   = ir_q[INSTR_W-5:0];

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Scoreboard bench for instr_fetch_seq: the memory driver predicts each
// instruction's retirement when it acks a fetch; a negedge monitor pops and
// checks whenever exec_en fires, and tracks expected pc/halted every cycle.
module tb_instr_fetch_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [3:0]  opcode;
    logic [11:0] operand;
    logic        pc_src;
    logic        jmp_uncond;
    logic        dmem_busy;
    logic        exec_en;
    logic [7:0]  pc;
    logic        halted;

    always #5 clk = ~clk;

    instr_fetch_seq #(.ADDR_W(8), .INSTR_W(16)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .opcode(opcode), .operand(operand),
        .pc_src(pc_src), .jmp_uncond(jmp_uncond),
        .dmem_busy(dmem_busy), .exec_en(exec_en),
        .pc(pc), .halted(halted)
    );

    // Control unit stand-in: F is the unconditional jump, C..F all raise pc_src
    // (so jumps also exercise jmp_uncond priority), C..E are undefined opcodes.
    assign jmp_uncond = (opcode == 4'hF);
    assign pc_src     = (opcode >= 4'hC);

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] word;
        logic [7:0]  npc;
        bit          ill;
    } rec_t;

    rec_t        q[$];
    rec_t        mr;
    logic [15:0] mem [256];
    int          total = 0;
    int          bad = 0;
    logic [7:0]  model_pc;
    bit          model_halted;
    logic [7:0]  mon_pc;
    bit          mon_halted;
    int          cyc;
    int          exec_cyc[$];
    int          max_wait = 0;
    int          wait_cnt = 0;
    int          busy_pct = 0;
    int          hcnt = 0;
    bit          force_busy = 0;
    bit          noise = 0;
    bit          ack_en = 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference rule for one instruction at address a.
    function automatic rec_t mk(input logic [7:0] a, input logic [15:0] w);
        rec_t r;
        r.pc   = a;
        r.word = w;
        r.ill  = 1'b0;
        if (w[15:12] == 4'hF) begin
            r.npc = w[7:0];
        end else if (w[15:12] >= 4'hC) begin
            r.npc = a;
            r.ill = 1'b1;
        end else begin
            r.npc = 8'((int'(a) + 1) % 256);
        end
        return r;
    endfunction

    function automatic logic [15:0] rnd_word();
        int r = $urandom_range(0, 99);
        logic [3:0] op;
        if (r < 3)       op = 4'hC + 4'($urandom_range(0, 2));
        else if (r < 18) op = 4'hF;
        else             op = 4'($urandom_range(0, 11));
        return {op, 12'($urandom)};
    endfunction

    // cycle index since reset release; exec at cycle 3 for a no-wait first instruction
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Monitor: reset values, per-cycle pc/halted, and scoreboard pops on exec_en.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req", 32'(imem_req), 32'd0);
            chk("rst_exec_en", 32'(exec_en), 32'd0);
            chk("rst_pc", 32'(pc), 32'd0);
            chk("rst_addr", 32'(imem_addr), 32'd0);
            chk("rst_halted", 32'(halted), 32'd0);
            chk("rst_opcode", 32'(opcode), 32'd0);
            chk("rst_operand", 32'(operand), 32'd0);
        end else begin
            chk("pc", 32'(pc), 32'(mon_pc));
            chk("halted", 32'(halted), 32'(mon_halted));
            if (mon_halted) chk("req_in_halt", 32'(imem_req), 32'd0);
            if (dmem_busy) chk("exec_en_busy", 32'(exec_en), 32'd0);
            if (exec_en) begin
                exec_cyc.push_back(cyc);
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL exec_unexpected: got exec_en=1 at pc %0h expected no retirement", pc);
                end else begin
                    mr = q.pop_front();
                    chk("exec_pc", 32'(pc), 32'(mr.pc));
                    chk("exec_opcode", 32'(opcode), 32'(mr.word[15:12]));
                    chk("exec_operand", 32'(operand), 32'(mr.word[11:0]));
                    mon_pc     = mr.npc;
                    mon_halted = mr.ill;
                end
            end
        end
    end

    // One cycle of memory/data-side stimulus, driven just after the rising edge.
    task automatic step();
        rec_t r;
        @(posedge clk);
        #1;
        dmem_busy = force_busy ? 1'b1 : ($urandom_range(0, 99) < busy_pct);
        if (imem_req && ack_en) begin
            chk("imem_addr", 32'(imem_addr), 32'(model_pc));
            if (wait_cnt > 0) begin
                imem_ack = 1'b0;
                wait_cnt--;
            end else begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr];
                if (!model_halted) begin
                    r = mk(model_pc, mem[model_pc]);
                    q.push_back(r);
                    model_pc     = r.npc;
                    model_halted = r.ill;
                end
                wait_cnt = $urandom_range(0, max_wait);
            end
        end else begin
            imem_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            imem_rdata = 16'($urandom);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        imem_ack   = 1'b0;
        dmem_busy  = 1'b0;
        force_busy = 1'b0;
        q.delete();
        exec_cyc.delete();
        model_pc     = 8'd0;
        model_halted = 1'b0;
        mon_pc       = 8'd0;
        mon_halted   = 1'b0;
        wait_cnt     = $urandom_range(0, max_wait);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = 16'd0;
        dmem_busy = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = rnd_word();

        // Linear fetch, same-cycle ack: retirements at cycles 3, 6, 9.
        mem[0] = 16'h1000; mem[1] = 16'h2000; mem[2] = 16'h5000; mem[3] = 16'h1000;
        do_reset();
        repeat (10) step();
        chk("lin_exec_count", 32'(exec_cyc.size()), 32'd3);
        if (exec_cyc.size() >= 3) begin
            chk("lin_cyc0", 32'(exec_cyc[0]), 32'd3);
            chk("lin_cyc1", 32'(exec_cyc[1]), 32'd6);
            chk("lin_cyc2", 32'(exec_cyc[2]), 32'd9);
        end
        chk("lin_pc", 32'(pc), 32'd3);

        // Ack held off 4 cycles at address 0: retirement moves to cycle 7.
        do_reset();
        wait_cnt = 4;
        repeat (8) step();
        chk("wait_exec_count", 32'(exec_cyc.size()), 32'd1);
        if (exec_cyc.size() >= 1) chk("wait_cyc0", 32'(exec_cyc[0]), 32'd7);

        // Jump with upper operand bits set lands on 0xFE, then 0xFF wraps to 0.
        mem[0] = 16'hFAFE; mem[8'hFE] = 16'h1111; mem[8'hFF] = 16'h2222;
        max_wait = 1; busy_pct = 20;
        do_reset();
        repeat (40) step();

        // Undefined opcode at address 2 halts; acks keep toggling while halted.
        mem[0] = 16'h1001; mem[1] = 16'h2002; mem[2] = 16'hC123;
        max_wait = 0; busy_pct = 0; noise = 1;
        do_reset();
        repeat (30) step();
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_pc", 32'(pc), 32'd2);
        chk("halt_req", 32'(imem_req), 32'd0);
        do_reset();
        chk("halt_cleared", 32'(halted), 32'd0);
        repeat (6) step();

        // Async reset in the middle of a stalled EXEC at 0x40.
        mem[0] = 16'hF040; mem[8'h40] = 16'h3000;
        noise = 0;
        do_reset();
        repeat (3) step();
        force_busy = 1'b1;
        repeat (5) step();
        chk("stall_pc", 32'(pc), 32'h40);
        chk("stall_exec_en", 32'(exec_en), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_pc", 32'(pc), 32'd0);
        chk("midrst_exec_en", 32'(exec_en), 32'd0);
        chk("midrst_req", 32'(imem_req), 32'd0);
        chk("midrst_opcode", 32'(opcode), 32'd0);
        do_reset();
        repeat (8) step();

        // Randomized program with waits, stalls and stray acks; reset after each halt.
        for (int i = 0; i < 256; i++) mem[i] = rnd_word();
        max_wait = 3; busy_pct = 30; noise = 1;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            step();
            if (model_halted) begin
                hcnt++;
                if (hcnt > 8) begin
                    hcnt = 0;
                    do_reset();
                end
            end
        end

        // Drain: no new fetches accepted, everything issued must retire.
        ack_en = 0; noise = 0; busy_pct = 0;
        repeat (10) step();
        chk("drain_queue", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
